rr_sel_4: RTL
=============

# rr_sel_4

Round-robin select sequencer sitting directly upstream of the 4:1 data mux. It arbitrates among four requesting sources, drives the mux select lines `s1`/`s0` with the winner's index, and holds that selection until the downstream consumer acknowledges the transfer. An optional hold-timeout forces rotation when a granted source stalls.

## Interface
Parameters:
- `MAX_HOLD`, default 16: cycles a grant may be held without `ack` before forced rotation. Legal range 1..255. Only used when `RR_SEL_TIMEOUT_EN` is defined.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: request per source; bit k corresponds to mux data input `ik`.
- `ack` input 1: consumer accepted the currently selected data; meaningful only while `gnt_valid`=1.
- `s1` output 1: mux select MSB (`sel[1]`), registered.
- `s0` output 1: mux select LSB (`sel[0]`), registered.
- `gnt` output 4: one-hot grant, registered; 0000 when no grant.
- `gnt_valid` output 1: selection on `s1`/`s0` is valid.
- `to_pulse` output 1: one-cycle pulse on forced rotation; constant 0 when the timeout is compiled out.

## Operation
- Internal state: `state` ∈ {IDLE, BUSY}; 2-bit priority pointer `ptr`; 8-bit `hold_cnt` (timeout build only).
- Winner function: the first set bit of `req` scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
- IDLE:
  - If `req`≠0: at the next edge, load `sel` with the winner, set `gnt` to the matching one-hot value, set `gnt_valid`=1, clear `hold_cnt`, go to BUSY.
  - Otherwise stay in IDLE; `s1`/`s0` keep their last value.
- BUSY, release event: a release is `ack`=1, or `req[sel]`=0 (requester withdrew), or a timeout.
  - On release, `ptr` ← `sel+1` (mod 4) and the winner is recomputed from the current `req` with that new pointer, excluding `sel`.
  - If a winner exists, grant it at the same edge and stay in BUSY. Back-to-back grants have no bubble.
  - Otherwise `gnt_valid`←0, `gnt`←0000, go to IDLE.
- BUSY, no release: hold `sel`, `gnt`, `gnt_valid`; `hold_cnt` increments, saturating at 255.
- Simultaneous `ack` and timeout at the same edge count as `ack`; `to_pulse` stays 0.
- `ack` while `gnt_valid`=0 is ignored.
- A source requesting alone is re-granted immediately after its own release only via IDLE: at least one cycle with `gnt_valid`=0 between two grants to the same source.
- Reset (asynchronous, at any time including mid-grant):
  - `state`=IDLE, `ptr`=0, `hold_cnt`=0.
  - `s1`=0, `s0`=0, `gnt`=0000, `gnt_valid`=0, `to_pulse`=0.
  - Arbitration resumes on the first edge after `rst` falls.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled at edge N; `gnt_valid`/`s1`/`s0` valid after edge N.
- Release-to-next-grant latency: 0 cycles (same edge) for a different source; 2 edges for the same source.
- Timeout: if `ack` stays low for `MAX_HOLD` consecutive BUSY cycles after a grant, release occurs at the edge ending the `MAX_HOLD`-th cycle.
- `to_pulse`=1 for exactly the cycle following that edge.
- All outputs are registered; there is no combinational path from `req`/`ack` to any output.

## Configuration
- `RR_SEL_TIMEOUT_EN` defined:
  - `hold_cnt` and timeout release are implemented.
  - `to_pulse` is driven as described above.
- `RR_SEL_TIMEOUT_EN` undefined:
  - No counter is implemented; the grant is held indefinitely until `ack` or request withdrawal.
  - `to_pulse` is tied to 0 and `MAX_HOLD` is ignored.

## Test plan
- Reset mid-grant: `req`=0100 granted (`s1 s0`=10), then assert `rst` between edges → outputs drop immediately to `s1 s0`=00, `gnt`=0000, `gnt_valid`=0; after release, `req`=0001 → grant to 0 (pointer back to 0).
- Fairness: `req`=1111 held, `ack` pulsed every cycle of BUSY → `s1 s0` sequence 00,01,10,11,00 with `gnt_valid` continuously 1.
- Skip idle sources: `req`=1010, `ptr`=0 → grant 1 (`gnt`=0010); `ack` → grant 3 (`gnt`=1000); `ack` → grant 1.
- Withdrawal: granted source 2 drops `req[2]` with `ack`=0 and `req`=0000 → `gnt_valid`=0 next edge; next `req`=0100 → regranted after one idle cycle.
- Timeout (macro on, `MAX_HOLD`=4): `req`=0011, `ack`=0 → source 0 held 4 cycles, then source 1 granted with `to_pulse`=1 for one cycle. With macro off → source 0 held indefinitely and `to_pulse` stays 0.
- Ack-timeout collision (macro on): `ack`=1 on the 4th held cycle → normal rotation, `to_pulse`=0.

Source files
------------

// File: rtl/rr_sel_4.sv
// Round-robin select sequencer driving the s1/s0 lines of a 4:1 data mux.
// Define RR_SEL_TIMEOUT_EN to add the MAX_HOLD hold-timeout and the to_pulse output.
module rr_sel_4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ack,
    output logic       s1,
    output logic       s0,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       to_pulse
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic       vld_q, vld_d;
    logic       tmo;
    logic       release_ev;
    logic [2:0] win;

    // Returns {found, index}: first eligible request scanning from p upward, mod 4.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p,
                                        input logic [3:0] excl);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!res[2] && r[idx] && !excl[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef RR_SEL_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;
    logic       tp_q, tp_d;

    assign tmo      = (hold_q >= HOLD_LAST);
    assign to_pulse = tp_q;
`else
    logic unused_max_hold;

    assign unused_max_hold = ^MAX_HOLD;
    assign tmo             = 1'b0;
    assign to_pulse        = 1'b0;
`endif

    assign release_ev = ack || !req[sel_q] || tmo;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        win     = 3'b000;
`ifdef RR_SEL_TIMEOUT_EN
        hold_d  = hold_q;
        tp_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                win = pick(req, ptr_q, 4'b0000);
                if (win[2]) begin
                    sel_d   = win[1:0];
                    gnt_d   = 4'b0001 << win[1:0];
                    vld_d   = 1'b1;
                    state_d = BUSY;
`ifdef RR_SEL_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            BUSY: begin
                if (release_ev) begin
                    ptr_d = sel_q + 2'd1;
                    // The releasing source is excluded so it must pass through IDLE.
                    win   = pick(req, sel_q + 2'd1, 4'b0001 << sel_q);
`ifdef RR_SEL_TIMEOUT_EN
                    tp_d   = tmo && !ack;
                    hold_d = 8'd0;
`endif
                    if (win[2]) begin
                        sel_d = win[1:0];
                        gnt_d = 4'b0001 << win[1:0];
                    end else begin
                        gnt_d   = 4'b0000;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
`ifdef RR_SEL_TIMEOUT_EN
                    if (hold_q != 8'hFF) begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            vld_q   <= 1'b0;
`ifdef RR_SEL_TIMEOUT_EN
            hold_q  <= 8'd0;
            tp_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
`ifdef RR_SEL_TIMEOUT_EN
            hold_q  <= hold_d;
            tp_q    <= tp_d;
`endif
        end
    end

    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign gnt       = gnt_q;
    assign gnt_valid = vld_q;

endmodule
